// File: rtl/pc_gen_if.sv
// rtl/pc_gen_if.sv - fetch PC generator redirect/status bundle
interface pc_gen_if #(
  parameter int XLEN    = 32,
  parameter int FETCH_W = 1
) ();
  logic              stall_i;
  logic              trap_valid_i;
  logic [XLEN-1:0]   trap_addr_i;
  logic              br_valid_i;
  logic [XLEN-1:0]   br_addr_i;
  logic              pred_valid_i;
  logic [XLEN-1:0]   pred_addr_i;
  logic              ras_push_i;
  logic [XLEN-1:0]   ras_push_addr_i;
  logic              ras_pop_i;
  logic [XLEN-1:0]   pc_o;
  logic              pc_valid_o;
  logic [FETCH_W-1:0] grp_mask_o;
  logic              misalign_o;
  logic              ras_empty_o;

  // Hazard/EX side: drives redirects, observes the fetch PC
  modport master (
    output stall_i, trap_valid_i, trap_addr_i, br_valid_i, br_addr_i,
           pred_valid_i, pred_addr_i, ras_push_i, ras_push_addr_i, ras_pop_i,
    input  pc_o, pc_valid_o, grp_mask_o, misalign_o, ras_empty_o
  );

  // PC generator side
  modport slave (
    input  stall_i, trap_valid_i, trap_addr_i, br_valid_i, br_addr_i,
           pred_valid_i, pred_addr_i, ras_push_i, ras_push_addr_i, ras_pop_i,
    output pc_o, pc_valid_o, grp_mask_o, misalign_o, ras_empty_o
  );
endinterface

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - registered fetch PC with prioritised redirects and circular RAS
module pc_gen #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              FETCH_W   = 1,
  parameter int              RAS_DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  pc_gen_if.slave bus
);
  localparam int GB = $clog2(FETCH_W) + 2;
  localparam int SW = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;
  localparam int PW = $clog2(RAS_DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            pc_valid_q, pc_valid_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW:0]     cnt_q, cnt_d;
  logic [XLEN-1:0] ras_mem_q [RAS_DEPTH];

  logic            ras_we;
  logic [PW-1:0]   ras_widx;
  logic            ras_empty;
  logic            ras_ok;
  logic            pop_hit;
  logic [XLEN-1:0] seq_pc;
  logic [SW-1:0]   slot;

  assign ras_empty = (cnt_q == '0);
  // RAS only moves on a cycle that actually advances fetch
  assign ras_ok    = pc_valid_q && !bus.trap_valid_i && !bus.br_valid_i && !bus.stall_i;
  assign pop_hit   = bus.ras_pop_i && !ras_empty;
  assign seq_pc    = {pc_q[XLEN-1:GB], GB'(0)} + XLEN'(4 * FETCH_W);
  // Slot offset within the group; forced to zero for single-issue fetch
  assign slot      = pc_q[SW+1:2] & SW'(FETCH_W - 1);

  // Next-PC selection by redirect priority
  always_comb begin
    pc_valid_d = 1'b1;
    pc_d       = pc_q;
    if (bus.trap_valid_i)      pc_d = bus.trap_addr_i;
    else if (bus.br_valid_i)   pc_d = bus.br_addr_i;
    else if (bus.stall_i)      pc_d = pc_q;
    else if (pop_hit)          pc_d = ras_mem_q[ptr_q];
    else if (bus.pred_valid_i) pc_d = bus.pred_addr_i;
    else if (pc_valid_q)       pc_d = seq_pc;
    else                       pc_d = pc_q;
  end

  // RAS pointer/count update; a full push silently drops the oldest entry
  always_comb begin
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    ras_we   = 1'b0;
    ras_widx = ptr_q;
    if (ras_ok) begin
      if (bus.ras_push_i && pop_hit) begin
        ras_we   = 1'b1;
        ras_widx = ptr_q;
      end else if (bus.ras_push_i) begin
        ptr_d    = ptr_q + PW'(1);
        ras_we   = 1'b1;
        ras_widx = ptr_q + PW'(1);
        if (cnt_q != (PW+1)'(RAS_DEPTH)) cnt_d = cnt_q + (PW+1)'(1);
      end else if (pop_hit) begin
        ptr_d = ptr_q - PW'(1);
        cnt_d = cnt_q - (PW+1)'(1);
      end
    end
  end

  // PC and RAS control registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q       <= RESET_VEC;
      pc_valid_q <= 1'b0;
      ptr_q      <= '0;
      cnt_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // RAS storage; contents survive reset, only the count is cleared
  always_ff @(posedge clk) begin
    if (rst && ras_we) ras_mem_q[ras_widx] <= bus.ras_push_addr_i;
  end

  // Group slot mask: slots at or after the entry offset are live
  always_comb begin
    bus.grp_mask_o = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      bus.grp_mask_o[i] = (32'(i) >= 32'(slot));
    end
  end

  assign bus.pc_o        = pc_q;
  assign bus.pc_valid_o  = pc_valid_q;
  assign bus.misalign_o  = |pc_q[1:0];
  assign bus.ras_empty_o = ras_empty;
endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - randomized and directed check of pc_gen against a queue-based model
module tb_pc_gen;
  localparam logic [31:0] RV = 32'h100;
  localparam int DEPTH = 4;

  typedef logic [31:0] addr_q_t [$];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        stall, trap_v, br_v, pred_v, push, pop;
  logic [31:0] trap_a, br_a, pred_a, push_a;

  pc_gen_if #(.XLEN(32), .FETCH_W(1)) if1 ();
  pc_gen_if #(.XLEN(32), .FETCH_W(2)) if2 ();

  assign if1.stall_i = stall;  assign if2.stall_i = stall;
  assign if1.trap_valid_i = trap_v;  assign if2.trap_valid_i = trap_v;
  assign if1.trap_addr_i = trap_a;  assign if2.trap_addr_i = trap_a;
  assign if1.br_valid_i = br_v;  assign if2.br_valid_i = br_v;
  assign if1.br_addr_i = br_a;  assign if2.br_addr_i = br_a;
  assign if1.pred_valid_i = pred_v;  assign if2.pred_valid_i = pred_v;
  assign if1.pred_addr_i = pred_a;  assign if2.pred_addr_i = pred_a;
  assign if1.ras_push_i = push;  assign if2.ras_push_i = push;
  assign if1.ras_push_addr_i = push_a;  assign if2.ras_push_addr_i = push_a;
  assign if1.ras_pop_i = pop;  assign if2.ras_pop_i = pop;

  pc_gen #(.XLEN(32), .RESET_VEC(RV), .FETCH_W(1), .RAS_DEPTH(DEPTH)) dut1 (
    .clk(clk), .rst(rst), .bus(if1));
  pc_gen #(.XLEN(32), .RESET_VEC(RV), .FETCH_W(2), .RAS_DEPTH(DEPTH)) dut2 (
    .clk(clk), .rst(rst), .bus(if2));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [31:0] m_pc1, m_pc2;
  bit          m_v1, m_v2;
  addr_q_t     q1, q2;

  function automatic logic [31:0] mask_of(input int fw, input logic [31:0] pc);
    logic [31:0] m = '0;
    int slot = int'((pc >> 2) % 32'(fw));
    for (int i = 0; i < fw; i++) if (i >= slot) m[i] = 1'b1;
    return m;
  endfunction

  // Reference: next PC by the redirect priority list, RAS as a bounded stack
  task automatic model_step(input int fw, inout logic [31:0] pc, inout bit v, ref addr_q_t q);
    logic [31:0] np;
    longint g = longint'(4 * fw);
    bit hit, ok;
    if (!rst) begin
      pc = RV; v = 1'b0; q.delete();
      return;
    end
    hit = pop && (q.size() > 0);
    ok  = v && !trap_v && !br_v && !stall;
    if (trap_v)      np = trap_a;
    else if (br_v)   np = br_a;
    else if (stall)  np = pc;
    else if (hit)    np = q[q.size()-1];
    else if (pred_v) np = pred_a;
    else if (v)      np = 32'(((longint'(pc) / g) * g + g) % 64'h1_0000_0000);
    else             np = RV;
    if (ok) begin
      if (push && hit) q[q.size()-1] = push_a;
      else if (push) begin
        q.push_back(push_a);
        if (q.size() > DEPTH) q.delete(0);
      end else if (hit) void'(q.pop_back());
    end
    pc = np; v = 1'b1;
  endtask

  task automatic check_all();
    chk("pc1", if1.pc_o, m_pc1);
    chk("valid1", 32'(if1.pc_valid_o), 32'(m_v1));
    chk("mask1", 32'(if1.grp_mask_o), mask_of(1, m_pc1));
    chk("mis1", 32'(if1.misalign_o), 32'(m_pc1[1:0] != 2'b00));
    chk("empty1", 32'(if1.ras_empty_o), 32'(q1.size() == 0));
    chk("pc2", if2.pc_o, m_pc2);
    chk("valid2", 32'(if2.pc_valid_o), 32'(m_v2));
    chk("mask2", 32'(if2.grp_mask_o), mask_of(2, m_pc2));
    chk("mis2", 32'(if2.misalign_o), 32'(m_pc2[1:0] != 2'b00));
    chk("empty2", 32'(if2.ras_empty_o), 32'(q2.size() == 0));
  endtask

  task automatic cycle();
    model_step(1, m_pc1, m_v1, q1);
    model_step(2, m_pc2, m_v2, q2);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    stall = 0; trap_v = 0; br_v = 0; pred_v = 0; push = 0; pop = 0;
    trap_a = 0; br_a = 0; pred_a = 0; push_a = 0;
  endtask

  bit prev_rst;

  initial begin
    idle();
    rst = 0;
    m_pc1 = RV; m_pc2 = RV; m_v1 = 0; m_v2 = 0;
    // T1 reset and sequential fetch
    cycle(); cycle();
    chk("t1_rst_pc", if1.pc_o, 32'h100);
    chk("t1_rst_valid", 32'(if1.pc_valid_o), 32'd0);
    rst = 1;
    cycle();
    chk("t1_rel_pc", if1.pc_o, 32'h100);
    chk("t1_rel_valid", 32'(if1.pc_valid_o), 32'd1);
    cycle(); chk("t1_seq1", if1.pc_o, 32'h104);
    cycle(); chk("t1_seq2", if1.pc_o, 32'h108);
    // T2 two-wide group entry mid-group
    br_v = 1; br_a = 32'h1004;
    cycle(); idle();
    chk("t2_pc", if2.pc_o, 32'h1004);
    chk("t2_mask", 32'(if2.grp_mask_o), 32'b10);
    cycle(); chk("t2_pc2", if2.pc_o, 32'h1008);
    chk("t2_mask2", 32'(if2.grp_mask_o), 32'b11);
    cycle(); chk("t2_pc3", if2.pc_o, 32'h1010);
    // T3 priority
    trap_v = 1; trap_a = 32'h80; br_v = 1; br_a = 32'h200; stall = 1;
    cycle(); chk("t3_trap", if1.pc_o, 32'h80);
    trap_v = 0;
    cycle(); chk("t3_br", if1.pc_o, 32'h200);
    br_v = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(); chk("t3_hold", if1.pc_o, 32'h200);
    end
    idle();
    // T4 RAS push/pop
    push = 1;
    push_a = 32'hA0; cycle();
    push_a = 32'hB0; cycle();
    push_a = 32'hC0; cycle();
    idle(); pop = 1;
    cycle(); chk("t4_pop1", if1.pc_o, 32'hC0);
    cycle(); chk("t4_pop2", if1.pc_o, 32'hB0);
    cycle(); chk("t4_pop3", if1.pc_o, 32'hA0);
    chk("t4_empty", 32'(if1.ras_empty_o), 32'd1);
    cycle(); chk("t4_pop4_seq", if1.pc_o, 32'hA4);
    idle();
    // T5 overflow, then push+pop on same cycle
    push = 1;
    for (int i = 1; i <= 5; i++) begin
      push_a = 32'(i * 16); cycle();
    end
    idle(); pop = 1;
    cycle(); chk("t5_pop50", if1.pc_o, 32'h50);
    cycle(); chk("t5_pop40", if1.pc_o, 32'h40);
    cycle(); chk("t5_pop30", if1.pc_o, 32'h30);
    push = 1; push_a = 32'h70;
    cycle(); chk("t5_pushpop", if1.pc_o, 32'h20);
    push = 0;
    cycle(); chk("t5_newtop", if1.pc_o, 32'h70);
    chk("t5_empty", 32'(if1.ras_empty_o), 32'd1);
    idle();
    // T6 wrap, misaligned predictor target, reset during RAS activity
    br_v = 1; br_a = 32'hFFFF_FFFC;
    cycle(); idle();
    cycle(); chk("t6_wrap1", if1.pc_o, 32'h0);
    chk("t6_wrap2", if2.pc_o, 32'h0);
    pred_v = 1; pred_a = 32'h1002;
    cycle(); idle();
    chk("t6_mis", 32'(if1.misalign_o), 32'd1);
    push = 1; push_a = 32'h300; cycle();
    rst = 0; pop = 1; trap_v = 1; trap_a = 32'h44;
    cycle(); idle(); rst = 1;
    chk("t6_rst_pc", if1.pc_o, RV);
    chk("t6_rst_empty", 32'(if1.ras_empty_o), 32'd1);
    chk("t6_rst_valid", 32'(if1.pc_valid_o), 32'd0);
    cycle();
    // Randomized traffic
    prev_rst = 0;
    for (int n = 0; n < 3000; n++) begin
      rst    = ($urandom_range(0, 60) != 0);
      trap_v = ($urandom_range(0, 15) == 0);
      br_v   = ($urandom_range(0, 9) == 0);
      stall  = ($urandom_range(0, 4) == 0);
      pred_v = ($urandom_range(0, 4) == 0);
      push   = ($urandom_range(0, 3) == 0);
      pop    = ($urandom_range(0, 3) == 0);
      trap_a = $urandom();
      br_a   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
      pred_a = $urandom() & 32'h0000_FFFF;
      push_a = $urandom() & 32'h0000_FFFC;
      if (prev_rst) begin
        pred_v = 0; push = 0; pop = 0;
      end
      prev_rst = !rst;
      cycle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
